// File: rtl/decoder_arbiter.sv
// decoder_arbiter
// ---------------------------------------------------------------------------
// Round-robin arbiter that shares one 2-to-4 decoder between four requesters.
// One requester owns the decoder per grant period. This block drives the
// decoder's select and active-low enable, and presents a registered one-hot
// grant vector so each requester can see its own grant.
//
// Parameters:
//   HOLD_MAX    maximum consecutive GRANT cycles per grant (legal 2..255);
//               only used when DECODER_ARB_TIMEOUT_EN is defined
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous, active-low reset
//   req[3:0]    level requests; req[i] stays high while i wants/holds the decoder
//   d_sel[1:0]  decoder d_in select, index of the current grantee
//   en_n        decoder active-low enable (0 while a grant is active)
//   gnt[3:0]    registered one-hot grant, all zero when nobody owns the decoder
//   busy        high while in GRANT
//   timeout     one-cycle pulse when a grant is force-released
//
// Optional feature macro:
//   DECODER_ARB_TIMEOUT_EN  when defined, an 8-bit saturating hold counter
//                           force-releases a grant after HOLD_MAX cycles.
//                           When undefined, a grant lasts until the owner
//                           drops its request and timeout is tied low.
// ---------------------------------------------------------------------------
module decoder_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [1:0] d_sel,
    output logic       en_n,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [1:0] winner;
    logic [1:0] d_sel_nxt;
    logic [3:0] gnt_nxt;
    logic       en_n_nxt;
    logic       busy_nxt;
    logic       timeout_nxt;
    logic       hold_expired;

    // Reject illegal HOLD_MAX values at elaboration time.
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("decoder_arbiter: HOLD_MAX must be in 2..255");
    end

`ifdef DECODER_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt, hold_cnt_nxt;
    // hold_cnt is 0 in the first grant cycle, so reaching HOLD_MAX-1 means
    // the owner has had HOLD_MAX cycles.
    assign hold_expired = (hold_cnt == 8'(HOLD_MAX - 1));
`else
    assign hold_expired = 1'b0;
`endif

    // Round-robin search: ptr+1, ptr+2, ptr+3, ptr. The loop runs from the
    // lowest priority up so the highest-priority hit is the last write.
    always_comb begin
        winner = ptr;
        for (int i = 4; i >= 1; i--) begin
            if (req[ptr + 2'(i)]) begin
                winner = ptr + 2'(i);
            end
        end
    end

    // Next-state and next-output logic. Every output is computed here and
    // registered below, so there is no combinational path from req.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        d_sel_nxt   = d_sel;
        gnt_nxt     = gnt;
        en_n_nxt    = en_n;
        busy_nxt    = busy;
        timeout_nxt = 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
        hold_cnt_nxt = hold_cnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    ptr_nxt   = winner;
                    d_sel_nxt = winner;
                    gnt_nxt   = 4'b0001 << winner;
                    en_n_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
`ifdef DECODER_ARB_TIMEOUT_EN
                    hold_cnt_nxt = 8'd0;
`endif
                end
            end
            GRANT: begin
                // A voluntary drop takes precedence over a coincident timeout.
                if (!req[d_sel] || hold_expired) begin
                    state_nxt   = GAP;
                    gnt_nxt     = 4'b0000;
                    en_n_nxt    = 1'b1;
                    busy_nxt    = 1'b0;
                    timeout_nxt = req[d_sel];
                end
`ifdef DECODER_ARB_TIMEOUT_EN
                else if (hold_cnt != 8'hFF) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
`endif
            end
            GAP: begin
                // Dead cycle after every release; d_sel keeps its last value.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr     <= 2'd3;
            d_sel   <= 2'd0;
            gnt     <= 4'b0000;
            en_n    <= 1'b1;
            busy    <= 1'b0;
            timeout <= 1'b0;
`ifdef DECODER_ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            d_sel   <= d_sel_nxt;
            gnt     <= gnt_nxt;
            en_n    <= en_n_nxt;
            busy    <= busy_nxt;
            timeout <= timeout_nxt;
`ifdef DECODER_ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_decoder_arbiter.sv
// tb_decoder_arbiter
// ---------------------------------------------------------------------------
// Self-checking bench for decoder_arbiter (HOLD_MAX = 4). Expected grantees
// are queued when requests are driven and popped when a grant appears.
// Inputs are driven and outputs sampled on the falling clock edge.
// Honours DECODER_ARB_TIMEOUT_EN to pick the timeout or no-timeout scenario.
// ---------------------------------------------------------------------------
module tb_decoder_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [1:0] d_sel;
    logic       en_n;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    decoder_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .d_sel   (d_sel),
        .en_n    (en_n),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Returns at the negedge where gnt is non-zero; dead counts the zero
    // negedges seen first (20 means the wait expired).
    task automatic wait_grant(output int dead);
        dead = 0;
        @(negedge clk);
        while (gnt === 4'b0000 && dead < 20) begin
            dead++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [1:0] e;
        reset_n = 1'b0;
        req     = 4'b1111;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, d_sel, en_n, busy, timeout} !== {4'b0000, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state: got %b required %b",
                     {gnt, d_sel, en_n, busy, timeout}, {4'b0000, 2'd0, 1'b1, 1'b0, 1'b0});
        end
        reset_n = 1'b1;
        exp_q.push_back(0);
        @(negedge clk);
        e = (exp_q.size() != 0) ? 2'(exp_q.pop_front()) : 2'd0;
        checks++;
        if ({gnt, d_sel, en_n, busy} !== {4'b0001 << e, e, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL first_grant: got %b required %b",
                     {gnt, d_sel, en_n, busy}, {4'b0001 << e, e, 1'b0, 1'b1});
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    // Runs n grants with request pattern pat, each owner dropping its
    // request after 3 grant cycles and re-raising it during the GAP cycle.
    task automatic run_grants(input string tag, input logic [3:0] pat, input int n);
        int         dead;
        logic [1:0] e;
        req = pat;
        for (int k = 0; k < n; k++) begin
            wait_grant(dead);
            checks++;
            if (dead >= 20 || (k > 0 && dead != 1)) begin
                failures++;
                $display("[TB] FAIL %s_idle_gap[%0d]: got %0d zero cycles before grant, required 1",
                         tag, k, dead);
            end
            e = (exp_q.size() != 0) ? 2'(exp_q.pop_front()) : 2'd0;
            checks++;
            if ({gnt, d_sel, en_n, busy} !== {4'b0001 << e, e, 1'b0, 1'b1}) begin
                failures++;
                $display("[TB] FAIL %s_grant[%0d]: got %b required %b",
                         tag, k, {gnt, d_sel, en_n, busy}, {4'b0001 << e, e, 1'b0, 1'b1});
            end
            repeat (2) @(negedge clk);
            req[e] = 1'b0;
            @(negedge clk);
            checks++;
            if ({gnt, d_sel, en_n, busy, timeout} !== {4'b0000, e, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("[TB] FAIL %s_gap[%0d]: got %b required %b",
                         tag, k, {gnt, d_sel, en_n, busy, timeout}, {4'b0000, e, 1'b1, 1'b0, 1'b0});
            end
            req[e] = pat[e];
        end
    endtask

    task automatic test_rotation();
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        run_grants("rot", 4'b1111, 5);
    endtask

    // Continues from the rotation, which leaves ptr = 0.
    task automatic test_sparse();
        exp_q.push_back(1);
        exp_q.push_back(3);
        exp_q.push_back(1);
        exp_q.push_back(3);
        run_grants("sparse", 4'b1010, 4);
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

`ifdef DECODER_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int         dead;
        int         cnt;
        logic [1:0] e;
        do_reset();
        req = 4'b0100;
        exp_q.push_back(2);
        wait_grant(dead);
        e = (exp_q.size() != 0) ? 2'(exp_q.pop_front()) : 2'd0;
        checks++;
        if (dead >= 20 || gnt !== (4'b0001 << e)) begin
            failures++;
            $display("[TB] FAIL to_grant: got %b required %b", gnt, 4'b0001 << e);
        end
        cnt = 1;
        @(negedge clk);
        while (gnt === 4'b0100 && cnt < 300) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 4) begin
            failures++;
            $display("[TB] FAIL to_hold_len: got %0d cycles required 4", cnt);
        end
        checks++;
        if ({gnt, en_n, busy, timeout} !== {4'b0000, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL to_pulse: got %b required %b",
                     {gnt, en_n, busy, timeout}, {4'b0000, 1'b1, 1'b0, 1'b1});
        end
        exp_q.push_back(2);
        @(negedge clk);
        checks++;
        if ({gnt, en_n, timeout} !== {4'b0000, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL to_pulse_end: got %b required %b",
                     {gnt, en_n, timeout}, {4'b0000, 1'b1, 1'b0});
        end
        @(negedge clk);
        e = (exp_q.size() != 0) ? 2'(exp_q.pop_front()) : 2'd0;
        checks++;
        if ({gnt, d_sel, en_n} !== {4'b0001 << e, e, 1'b0}) begin
            failures++;
            $display("[TB] FAIL to_regrant: got %b required %b",
                     {gnt, d_sel, en_n}, {4'b0001 << e, e, 1'b0});
        end
        // Drop on the very edge where the timeout would fire: voluntary.
        repeat (3) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if ({gnt, en_n, timeout} !== {4'b0000, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL to_coincident_drop: got %b required %b",
                     {gnt, en_n, timeout}, {4'b0000, 1'b1, 1'b0});
        end
        repeat (3) @(negedge clk);
    endtask
`else
    task automatic test_no_timeout();
        int         dead;
        int         bad;
        logic [1:0] e;
        do_reset();
        req = 4'b0100;
        exp_q.push_back(2);
        wait_grant(dead);
        e = (exp_q.size() != 0) ? 2'(exp_q.pop_front()) : 2'd0;
        checks++;
        if (dead >= 20 || {gnt, d_sel} !== {4'b0001 << e, e}) begin
            failures++;
            $display("[TB] FAIL nto_grant: got %b required %b", {gnt, d_sel}, {4'b0001 << e, e});
        end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (gnt !== 4'b0100 || en_n !== 1'b0 || timeout !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL nto_hold: got %0d bad cycles required 0", bad);
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask
`endif

    task automatic test_reset_mid_grant();
        int         dead;
        logic [1:0] e;
        do_reset();
        req = 4'b1000;
        exp_q.push_back(3);
        wait_grant(dead);
        e = (exp_q.size() != 0) ? 2'(exp_q.pop_front()) : 2'd0;
        checks++;
        if (dead >= 20 || {gnt, d_sel, en_n} !== {4'b0001 << e, e, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rst_mid_grant: got %b required %b",
                     {gnt, d_sel, en_n}, {4'b0001 << e, e, 1'b0});
        end
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, d_sel, en_n, busy, timeout} !== {4'b0000, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rst_async: got %b required %b",
                     {gnt, d_sel, en_n, busy, timeout}, {4'b0000, 2'd0, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        req     = 4'b1001;
        reset_n = 1'b1;
        exp_q.push_back(0);
        wait_grant(dead);
        e = (exp_q.size() != 0) ? 2'(exp_q.pop_front()) : 2'd3;
        checks++;
        if (dead != 0 || {gnt, d_sel, en_n} !== {4'b0001 << e, e, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rst_restart: got %b after %0d idle, required %b after 0",
                     {gnt, d_sel, en_n}, dead, {4'b0001 << e, e, 1'b0});
        end
        req = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        req     = 4'b0000;
        test_reset();
        test_rotation();
        test_sparse();
`ifdef DECODER_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_grant();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
